// File: rtl/tick_debouncer.sv
// Tick-paced debouncer: 2-flop synchroniser, 4-state acceptance FSM.
// Optional DEBOUNCE_PRESS_COUNT_EN adds an 8-bit wrapping press counter.
module tick_debouncer #(
    parameter int CNT_W        = 4,
    parameter int STABLE_TICKS = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       noisy_in,
    output logic       db_level,
    output logic       db_rise,
    output logic       db_fall
`ifdef DEBOUNCE_PRESS_COUNT_EN
    ,
    output logic [7:0] press_count
`endif
);

    typedef enum logic [1:0] {
        LOW,
        WAIT_HI,
        HIGH,
        WAIT_LO
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_TICKS - 1);

    state_t            state;
    state_t            state_n;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_n;
    logic              level_n;
    logic              rise_n;
    logic              fall_n;
    logic              s_meta;
    logic              s_in;

    // Bring the asynchronous input into the clk domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_meta <= 1'b0;
            s_in   <= 1'b0;
        end else begin
            s_meta <= noisy_in;
            s_in   <= s_meta;
        end
    end

    // State, stability counter and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= LOW;
            cnt      <= '0;
            db_level <= 1'b0;
            db_rise  <= 1'b0;
            db_fall  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            db_level <= level_n;
            db_rise  <= rise_n;
            db_fall  <= fall_n;
        end
    end

    // Next state: a bounce beats a coincident tick; ticks only count in WAIT.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        level_n = db_level;
        rise_n  = 1'b0;
        fall_n  = 1'b0;
        unique case (state)
            LOW: begin
                if (s_in) begin
                    state_n = WAIT_HI;
                    cnt_n   = '0;
                end
            end
            WAIT_HI: begin
                if (!s_in) begin
                    state_n = LOW;
                    cnt_n   = '0;
                end else if (tick) begin
                    if (cnt == LAST) begin
                        state_n = HIGH;
                        cnt_n   = '0;
                        level_n = 1'b1;
                        rise_n  = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            HIGH: begin
                if (!s_in) begin
                    state_n = WAIT_LO;
                    cnt_n   = '0;
                end
            end
            WAIT_LO: begin
                if (s_in) begin
                    state_n = HIGH;
                    cnt_n   = '0;
                end else if (tick) begin
                    if (cnt == LAST) begin
                        state_n = LOW;
                        cnt_n   = '0;
                        level_n = 1'b0;
                        fall_n  = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_n = LOW;
                cnt_n   = '0;
                level_n = 1'b0;
            end
        endcase
    end

`ifdef DEBOUNCE_PRESS_COUNT_EN
    // Count accepted presses; wraps freely at 8 bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            press_count <= 8'd0;
        end else if (rise_n) begin
            press_count <= press_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tick_debouncer.sv
// Bench for tick_debouncer: reference model plus directed scenarios.
// Press counter checks are active when DEBOUNCE_PRESS_COUNT_EN is defined.
module tb_tick_debouncer;

    localparam int CW = 4;
    localparam int ST = 3;

    logic       clk;
    logic       reset_n;
    logic       tick;
    logic       noisy_in;
    logic       db_level;
    logic       db_rise;
    logic       db_fall;
`ifdef DEBOUNCE_PRESS_COUNT_EN
    logic [7:0] press_count;
    logic [7:0] m_press;
`endif

    int vectors;
    int misc;
    int n_rise;
    int n_fall;

    tick_debouncer #(
        .CNT_W       (CW),
        .STABLE_TICKS(ST)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick),
        .noisy_in(noisy_in),
        .db_level(db_level),
        .db_rise (db_rise),
        .db_fall (db_fall)
`ifdef DEBOUNCE_PRESS_COUNT_EN
        ,
        .press_count(press_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: s_in is noisy_in two edges late; a level change is accepted
    // once s_in has disagreed with the level for one entry cycle plus ST ticks.
    logic m_s1, m_s2, m_level, m_rise, m_fall;
    int   m_age, m_ticks;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_s1    <= 1'b0;
            m_s2    <= 1'b0;
            m_level <= 1'b0;
            m_rise  <= 1'b0;
            m_fall  <= 1'b0;
            m_age   <= 0;
            m_ticks <= 0;
`ifdef DEBOUNCE_PRESS_COUNT_EN
            m_press <= 8'd0;
`endif
        end else begin
            m_s1   <= noisy_in;
            m_s2   <= m_s1;
            m_rise <= 1'b0;
            m_fall <= 1'b0;
            if (m_s2 == m_level) begin
                m_age   <= 0;
                m_ticks <= 0;
            end else if (m_age == 0) begin
                m_age <= 1;
            end else if (tick) begin
                if (m_ticks + 1 == ST) begin
                    m_level <= !m_level;
                    m_rise  <= !m_level;
                    m_fall  <= m_level;
                    m_age   <= 0;
                    m_ticks <= 0;
`ifdef DEBOUNCE_PRESS_COUNT_EN
                    if (!m_level) m_press <= m_press + 8'd1;
`endif
                end else begin
                    m_ticks <= m_ticks + 1;
                end
            end
        end
    end

    task automatic check_model();
        logic bad;
        vectors++;
        bad = (db_level !== m_level) || (db_rise !== m_rise) ||
              (db_fall !== m_fall) || (db_rise && db_fall);
`ifdef DEBOUNCE_PRESS_COUNT_EN
        bad = bad || (press_count !== m_press);
`endif
        if (bad) begin
            misc++;
            $display("FAIL model t=%0t got lvl/r/f=%b%b%b want %b%b%b",
                     $time, db_level, db_rise, db_fall,
                     m_level, m_rise, m_fall);
        end
        if (db_rise === 1'b1) n_rise++;
        if (db_fall === 1'b1) n_fall++;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            misc++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic nin, input logic tk);
        noisy_in = nin;
        tick     = tk;
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic run(input int n, input logic nin, input int per);
        for (int i = 0; i < n; i++) begin
            step(nin, (i % per) == per - 1);
        end
    endtask

    initial begin
        vectors  = 0;
        misc     = 0;
        n_rise   = 0;
        n_fall   = 0;
        reset_n  = 1'b0;
        noisy_in = 1'b0;
        tick     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_level", int'(db_level), 0);
        chk("reset_pulses", int'(db_rise) + int'(db_fall), 0);
        reset_n = 1'b1;

        // Idle low for 100 cycles.
        run(100, 1'b0, 4);
        chk("idle_level", int'(db_level), 0);
        chk("idle_pulses", n_rise + n_fall, 0);
`ifdef DEBOUNCE_PRESS_COUNT_EN
        chk("idle_press", int'(press_count), 0);
`endif

        // Clean rise, tick every 4: accepted on the 3rd counted tick (step 11).
        n_rise = 0;
        for (int i = 0; i < 11; i++) step(1'b1, (i % 4) == 3);
        chk("rise_before", int'(db_level), 0);
        step(1'b1, 1'b1);
        chk("rise_level", int'(db_level), 1);
        chk("rise_pulse", int'(db_rise), 1);
        for (int i = 12; i < 24; i++) step(1'b1, (i % 4) == 3);
        chk("rise_once", n_rise, 1);
`ifdef DEBOUNCE_PRESS_COUNT_EN
        chk("press_one", int'(press_count), 1);
`endif

        // Back to low.
        n_fall = 0;
        run(30, 1'b0, 4);
        chk("fall_level", int'(db_level), 0);
        chk("fall_once", n_fall, 1);

        // Bounce lands on the 3rd tick: s_in low in step 11.
        n_rise = 0;
        for (int i = 0; i < 12; i++) step(i < 9, (i % 4) == 3);
        run(20, 1'b0, 4);
        chk("bounce_level", int'(db_level), 0);
        chk("bounce_rise", n_rise, 0);

        // Get HIGH, then three short low bounces before a stable low.
        run(30, 1'b1, 4);
        chk("high_again", int'(db_level), 1);
        n_fall = 0;
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 4; i++) step(1'b0, i == 2);
            for (int i = 0; i < 2; i++) step(1'b1, i == 1);
        end
        chk("bounce_hold", int'(db_level), 1);
        chk("bounce_nofall", n_fall, 0);
        run(30, 1'b0, 4);
        chk("settle_low", int'(db_level), 0);
        chk("settle_fall", n_fall, 1);

        // Reset in WAIT_HI with counter 2, continuous tick.
        run(5, 1'b1, 1);
        chk("wait_level", int'(db_level), 0);
        #1 reset_n = 1'b0;
        #1 chk("async_rst", int'(db_level) + int'(db_rise), 0);
        @(negedge clk);
        check_model();
        reset_n = 1'b1;
        run(5, 1'b1, 1);
        chk("fresh_window", int'(db_level), 0);
        step(1'b1, 1'b1);
        chk("fresh_accept", int'(db_level), 1);
        chk("fresh_rise", int'(db_rise), 1);

        // Reset from HIGH must drop the level before the next edge.
        run(3, 1'b1, 1);
        #1 reset_n = 1'b0;
        #1 chk("async_high", int'(db_level), 0);
        @(negedge clk);
        check_model();
        reset_n = 1'b1;
        run(5, 1'b0, 1);

`ifdef DEBOUNCE_PRESS_COUNT_EN
        // 257 presses wrap the 8-bit counter to 1.
        for (int p = 0; p < 257; p++) begin
            run(7, 1'b1, 1);
            run(7, 1'b0, 1);
        end
        chk("press_wrap", int'(press_count), 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end

endmodule
